// File: rtl/forward_scoreboard.sv
// Operand forwarding (youngest stage wins) plus a pending-load scoreboard that
// raises load-use / WAW stalls, with a stall-cycle counter and stall watchdog.
module forward_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_FWD   = 2,
    parameter int REG_COUNT = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issueValid,
    input  logic [NUM_READ*5-1:0]    issueRs,
    input  logic [NUM_READ-1:0]      issueRsUsed,
    input  logic [4:0]               issueRd,
    input  logic                     issueIsLoad,
    input  logic [NUM_FWD-1:0]       fwdValid,
    input  logic [NUM_FWD-1:0]       fwdWriteEnable,
    input  logic [NUM_FWD-1:0]       fwdDataReady,
    input  logic [NUM_FWD*5-1:0]     fwdRd,
    input  logic [NUM_FWD*XLEN-1:0]  fwdData,
    input  logic                     loadDoneValid,
    input  logic [4:0]               loadDoneRd,
    input  logic                     flush,
    output logic [NUM_READ-1:0]      forwardEnable,
    output logic [NUM_READ*XLEN-1:0] forwardData,
    output logic                     stall,
    output logic [31:0]              stallCycles,
    output logic                     stallTimeout
);

    localparam int RUN_W = $clog2(TIMEOUT + 1);

    logic [REG_COUNT-1:0]     pending_q, pending_d;
    logic [31:0]              stall_cnt_q, stall_cnt_d;
    logic [RUN_W-1:0]         run_q, run_d;
    logic                     timeout_q, timeout_d;

    logic [NUM_READ-1:0]      fwd_en;
    logic [NUM_READ-1:0]      hazard;
    logic [NUM_READ-1:0]      matched;
    logic [NUM_READ*XLEN-1:0] fwd_data;
    logic                     waw;
    logic                     stall_raw;
    logic                     load_accept;

    // A pending bit counts as still set unless its load returns this very cycle.
    function automatic logic pending_live(input logic [REG_COUNT-1:0] pend,
                                          input logic [4:0]           r,
                                          input logic                 done_v,
                                          input logic [4:0]           done_rd);
        logic b;
        b = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (r == 5'(i)) b = pend[i];
        end
        return b && (r != 5'd0) && !(done_v && done_rd == r);
    endfunction

    // NOTE: every signal driven here gets a default before any condition, so no latch is inferred.
    always_comb begin
        fwd_en   = '0;
        fwd_data = '0;
        hazard   = '0;
        matched  = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            if (issueRsUsed[p] && issueRs[5*p +: 5] != 5'd0) begin
                // The youngest matching stage decides, even if its data is not ready yet.
                for (int s = 0; s < NUM_FWD; s++) begin
                    if (!matched[p] && fwdValid[s] && fwdWriteEnable[s] &&
                        fwdRd[5*s +: 5] == issueRs[5*p +: 5]) begin
                        matched[p] = 1'b1;
                        if (fwdDataReady[s]) begin
                            fwd_en[p]                = 1'b1;
                            fwd_data[XLEN*p +: XLEN] = fwdData[XLEN*s +: XLEN];
                        end else begin
                            hazard[p] = 1'b1;
                        end
                    end
                end
                if (pending_live(pending_q, issueRs[5*p +: 5], loadDoneValid, loadDoneRd)) begin
                    hazard[p] = 1'b1;
                end
            end
        end
    end

    assign waw         = issueIsLoad && pending_live(pending_q, issueRd, loadDoneValid, loadDoneRd);
    assign stall_raw   = issueValid && (|hazard || waw);
    assign load_accept = issueValid && !stall_raw && !flush && issueIsLoad;

    assign stall         = !reset && stall_raw;
    assign forwardEnable = reset ? '0 : fwd_en;
    assign forwardData   = reset ? '0 : fwd_data;
    assign stallCycles   = stall_cnt_q;
    assign stallTimeout  = timeout_q;

    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else begin
            // Clear first, then set, so a same-cycle set of the same register wins.
            for (int i = 1; i < REG_COUNT; i++) begin
                if (loadDoneValid && loadDoneRd == 5'(i)) pending_d[i] = 1'b0;
                if (load_accept && issueRd == 5'(i))      pending_d[i] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q + (stall ? 32'd1 : 32'd0);
        run_d       = run_q;
        if (!stall || flush) begin
            run_d = '0;
        end else if (run_q != RUN_W'(TIMEOUT)) begin
            run_d = run_q + 1'b1;
        end
        timeout_d = timeout_q || (run_d == RUN_W'(TIMEOUT));
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the scoreboard is a flop vector, not a RAM, so every bit is reset.
            pending_q   <= '0;
            stall_cnt_q <= '0;
            run_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed scenarios with literal expectations, then randomized traffic checked
// every cycle against a register-array reference model.
module tb_forward_scoreboard;

    localparam int XLEN = 32;
    localparam int NR   = 2;
    localparam int NF   = 2;
    localparam int RC   = 32;
    localparam int TO   = 64;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                issueValid;
    logic [NR*5-1:0]     issueRs;
    logic [NR-1:0]       issueRsUsed;
    logic [4:0]          issueRd;
    logic                issueIsLoad;
    logic [NF-1:0]       fwdValid;
    logic [NF-1:0]       fwdWriteEnable;
    logic [NF-1:0]       fwdDataReady;
    logic [NF*5-1:0]     fwdRd;
    logic [NF*XLEN-1:0]  fwdData;
    logic                loadDoneValid;
    logic [4:0]          loadDoneRd;
    logic                flush;
    logic [NR-1:0]       forwardEnable;
    logic [NR*XLEN-1:0]  forwardData;
    logic                stall;
    logic [31:0]         stallCycles;
    logic                stallTimeout;

    forward_scoreboard #(
        .XLEN(XLEN), .NUM_READ(NR), .NUM_FWD(NF), .REG_COUNT(RC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .issueValid(issueValid), .issueRs(issueRs), .issueRsUsed(issueRsUsed),
        .issueRd(issueRd), .issueIsLoad(issueIsLoad),
        .fwdValid(fwdValid), .fwdWriteEnable(fwdWriteEnable), .fwdDataReady(fwdDataReady),
        .fwdRd(fwdRd), .fwdData(fwdData),
        .loadDoneValid(loadDoneValid), .loadDoneRd(loadDoneRd), .flush(flush),
        .forwardEnable(forwardEnable), .forwardData(forwardData), .stall(stall),
        .stallCycles(stallCycles), .stallTimeout(stallTimeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: one flag per architectural register plus plain counters.
    bit          m_pend[RC];
    int unsigned m_stall_cnt = 0;
    int          m_run = 0;
    bit          m_timeout = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int r);
        return m_pend[r] && !(loadDoneValid && int'(loadDoneRd) == r);
    endfunction

    task automatic model_outputs(output logic [NR-1:0] fe, output logic [NR*XLEN-1:0] fd,
                                 output logic st);
        bit hz;
        hz = 1'b0;
        fe = '0;
        fd = '0;
        st = 1'b0;
        if (!reset) begin
            for (int p = 0; p < NR; p++) begin
                int r;
                r = int'(issueRs[5*p +: 5]);
                if (issueRsUsed[p] && r != 0) begin
                    if (m_busy(r)) hz = 1'b1;
                    for (int s = 0; s < NF; s++) begin
                        if (fwdValid[s] && fwdWriteEnable[s] && int'(fwdRd[5*s +: 5]) == r) begin
                            if (fwdDataReady[s]) begin
                                fe[p] = 1'b1;
                                fd[XLEN*p +: XLEN] = fwdData[XLEN*s +: XLEN];
                            end else begin
                                hz = 1'b1;
                            end
                            break;
                        end
                    end
                end
            end
            if (issueIsLoad && issueRd != 5'd0 && m_busy(int'(issueRd))) hz = 1'b1;
            st = issueValid && hz;
        end
    endtask

    task automatic model_advance(input logic st);
        if (reset) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_stall_cnt = 0;
            m_run       = 0;
            m_timeout   = 1'b0;
        end else begin
            if (st) m_stall_cnt++;
            if (!st || flush) m_run = 0;
            else if (m_run < TO) m_run++;
            if (m_run == TO) m_timeout = 1'b1;
            if (flush) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
            end else begin
                if (loadDoneValid) m_pend[loadDoneRd] = 1'b0;
                if (issueValid && !st && issueIsLoad && issueRd != 5'd0) m_pend[issueRd] = 1'b1;
            end
        end
    endtask

    // Compare process: every falling edge, outputs against the model, then step the model.
    initial begin
        logic [NR-1:0]      e_fe;
        logic [NR*XLEN-1:0] e_fd;
        logic               e_st;
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_outputs(e_fe, e_fd, e_st);
            check("cmp_forwardEnable", 64'(forwardEnable), 64'(e_fe));
            check("cmp_forwardData", 64'(forwardData), 64'(e_fd));
            check("cmp_stall", 64'(stall), 64'(e_st));
            check("cmp_stallCycles", 64'(stallCycles), 64'(m_stall_cnt));
            check("cmp_stallTimeout", 64'(stallTimeout), 64'(m_timeout));
            model_advance(e_st);
        end
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic idle();
        issueValid = 0; issueRs = '0; issueRsUsed = '0; issueRd = '0; issueIsLoad = 0;
        fwdValid = '0; fwdWriteEnable = '0; fwdDataReady = '0; fwdRd = '0; fwdData = '0;
        loadDoneValid = 0; loadDoneRd = '0; flush = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next();
        idle();
        reset = 1'b1;
        next();
        next();
        reset = 1'b0;
    endtask

    task automatic stage_hazard(input logic [4:0] r);
        idle();
        issueValid = 1; issueRsUsed = 2'b01; issueRs = {5'd0, r};
        fwdValid = 2'b01; fwdWriteEnable = 2'b01; fwdDataReady = 2'b00; fwdRd = {5'd0, r};
    endtask

    initial begin
        idle();
        do_reset();
        #1;
        check("reset_stallCycles", 64'(stallCycles), 64'd0);
        check("reset_stallTimeout", 64'(stallTimeout), 64'd0);

        // Youngest stage wins; an older stage is used only when the younger one misses.
        issueValid = 1; issueRsUsed = 2'b01; issueRs = {5'd0, 5'd5};
        fwdValid = 2'b11; fwdWriteEnable = 2'b11; fwdDataReady = 2'b11;
        fwdRd = {5'd5, 5'd5}; fwdData = {32'hBBBB_0002, 32'hAAAA_0001};
        #1;
        check("t1_fe0", 64'(forwardEnable[0]), 64'd1);
        check("t1_data_young", 64'(forwardData[31:0]), 64'h0000_0000_AAAA_0001);
        check("t1_stall", 64'(stall), 64'd0);
        next();
        fwdRd = {5'd5, 5'd6};
        #1;
        check("t1_data_old", 64'(forwardData[31:0]), 64'h0000_0000_BBBB_0002);

        // Young stage not ready: no fall-through to the ready older stage.
        next();
        idle();
        issueValid = 1; issueRsUsed = 2'b10; issueRs = {5'd7, 5'd0};
        fwdValid = 2'b11; fwdWriteEnable = 2'b11; fwdDataReady = 2'b10; fwdRd = {5'd7, 5'd7};
        #1;
        check("t2_stall", 64'(stall), 64'd1);
        check("t2_fe1", 64'(forwardEnable[1]), 64'd0);

        // Load-use: stall until the load returns, with the clear bypassed.
        do_reset();
        issueValid = 1; issueIsLoad = 1; issueRd = 5'd3;
        #1;
        check("t3_load_accept", 64'(stall), 64'd0);
        next();
        idle();
        issueValid = 1; issueRsUsed = 2'b01; issueRs = {5'd0, 5'd3}; issueRd = 5'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_use_stall", 64'(stall), 64'd1);
            next();
        end
        loadDoneValid = 1; loadDoneRd = 5'd3;
        #1;
        check("t3_done_nostall", 64'(stall), 64'd0);
        check("t3_stallCycles", 64'(stallCycles), 64'd5);

        // WAW stall, then a same-cycle clear+set leaves the register pending.
        do_reset();
        issueValid = 1; issueIsLoad = 1; issueRd = 5'd4;
        #1;
        check("t4_first_load", 64'(stall), 64'd0);
        next();
        #1;
        check("t4_waw", 64'(stall), 64'd1);
        next();
        loadDoneValid = 1; loadDoneRd = 5'd4;
        #1;
        check("t4_waw_bypass", 64'(stall), 64'd0);
        next();
        idle();
        issueValid = 1; issueRsUsed = 2'b01; issueRs = {5'd0, 5'd4}; issueRd = 5'd8;
        #1;
        check("t4_set_wins", 64'(stall), 64'd1);

        // Watchdog: timeout exactly after the TO-th consecutive stalled edge, sticky.
        do_reset();
        stage_hazard(5'd12);
        for (int i = 1; i <= TO; i++) begin
            next();
            #1;
            if (i == TO - 1) check("t5_no_timeout_early", 64'(stallTimeout), 64'd0);
        end
        check("t5_timeout", 64'(stallTimeout), 64'd1);
        check("t5_stallCycles", 64'(stallCycles), 64'(TO));
        idle();
        next();
        #1;
        check("t5_timeout_sticky", 64'(stallTimeout), 64'd1);

        // Flush mid-run restarts the run: 80 stalled edges, longest run 50.
        do_reset();
        stage_hazard(5'd12);
        for (int i = 1; i <= 80; i++) begin
            flush = (i == 30);
            next();
        end
        idle();
        #1;
        check("t5_flush_no_timeout", 64'(stallTimeout), 64'd0);
        check("t5_flush_stallCycles", 64'(stallCycles), 64'd80);

        // Register x0 never forwards, never stalls, never becomes pending.
        do_reset();
        issueValid = 1; issueRsUsed = 2'b11; issueRs = {5'd0, 5'd0};
        issueIsLoad = 1; issueRd = 5'd0;
        fwdValid = 2'b01; fwdWriteEnable = 2'b01; fwdDataReady = 2'b01;
        fwdRd = {5'd0, 5'd0}; fwdData = {32'd0, 32'hDEAD_BEEF};
        #1;
        check("t6_x0_fe", 64'(forwardEnable), 64'd0);
        check("t6_x0_data", 64'(forwardData), 64'd0);
        check("t6_x0_stall", 64'(stall), 64'd0);
        next();
        #1;
        check("t6_x0_not_pending", 64'(stall), 64'd0);

        // Reset mid-load: outputs gated during reset, pending discarded afterwards.
        next();
        idle();
        issueValid = 1; issueIsLoad = 1; issueRd = 5'd13;
        next();
        idle();
        reset = 1;
        issueValid = 1; issueRsUsed = 2'b01; issueRs = {5'd0, 5'd13};
        fwdValid = 2'b01; fwdWriteEnable = 2'b01; fwdDataReady = 2'b01;
        fwdRd = {5'd0, 5'd13}; fwdData = {32'd0, 32'h1234_5678};
        #1;
        check("t6_reset_stall", 64'(stall), 64'd0);
        check("t6_reset_fe", 64'(forwardEnable), 64'd0);
        check("t6_reset_data", 64'(forwardData), 64'd0);
        next();
        reset = 0;
        idle();
        loadDoneValid = 1; loadDoneRd = 5'd13;
        next();
        idle();
        issueValid = 1; issueRsUsed = 2'b01; issueRs = {5'd0, 5'd13}; issueIsLoad = 1; issueRd = 5'd13;
        #1;
        check("t6_after_reset_stall", 64'(stall), 64'd0);

        // Randomized traffic over a small register window to make collisions common.
        for (int c = 0; c < 3000; c++) begin
            next();
            reset         = ($urandom_range(0, 299) == 0);
            issueValid    = ($urandom_range(0, 3) != 0);
            issueRsUsed   = NR'($urandom);
            for (int p = 0; p < NR; p++) issueRs[5*p +: 5] = 5'($urandom_range(0, 7));
            issueRd       = 5'($urandom_range(0, 7));
            issueIsLoad   = ($urandom_range(0, 2) == 0);
            fwdValid      = NF'($urandom);
            fwdWriteEnable = NF'($urandom);
            for (int s = 0; s < NF; s++) begin
                fwdDataReady[s]       = ($urandom_range(0, 3) != 0);
                fwdRd[5*s +: 5]       = 5'($urandom_range(0, 7));
                fwdData[XLEN*s +: XLEN] = $urandom;
            end
            loadDoneValid = ($urandom_range(0, 3) == 0);
            loadDoneRd    = 5'($urandom_range(0, 7));
            flush         = ($urandom_range(0, 39) == 0);
        end
        next();
        idle();
        next();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
